// File: rtl/m_multicycle_control_unit.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with registered decode.
// Optional macro CU_MEM_TIMEOUT_EN bounds the MEM wait to P_MEM_TIMEOUT cycles.
module m_multicycle_control_unit #(
    parameter int P_WORD_WIDTH     = 8,
    parameter int P_REG_ADDR_WIDTH = 4,
    parameter int P_MEM_TIMEOUT    = 15
) (
    input  logic                        w_clock,
    input  logic                        w_reset,
    input  logic [P_WORD_WIDTH-1:0]     w_bus_wordin,
    input  logic                        w_instr_valid,
    input  logic                        w_cf,
    input  logic                        w_mem_ack,
    output logic                        w_instr_ready,
    output logic                        w_jump_flag,
    output logic                        w_store_word_flag,
    output logic                        w_store_pc_flag,
    output logic                        w_load_word_flag,
    output logic                        w_data_mem_write_flag,
    output logic                        w_write_back_flag,
    output logic [P_REG_ADDR_WIDTH-1:0] w_write_back_reg,
    output logic                        w_mem_req,
    output logic                        w_pc_enable,
    output logic [2:0]                  w_state,
    output logic                        w_mem_error
);

`ifdef CU_MEM_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam int TW = $clog2(P_MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4
    } state_t;

    state_t                      state, next_state;
    logic [P_WORD_WIDTH-1:0]     ir;
    logic [3:0]                  op;
    logic [P_REG_ADDR_WIDTH-1:0] rf;
    logic                        d_jump, d_store_word, d_store_pc, d_load_word, d_wb;
    logic [P_REG_ADDR_WIDTH-1:0] d_reg;
    logic                        jump_q, store_word_q, store_pc_q, load_word_q, wb_q;
    logic [P_REG_ADDR_WIDTH-1:0] reg_q;
    logic [TW-1:0]               timer;
    logic                        timeout, mem_error_q;

    assign op = ir[P_WORD_WIDTH-1 -: 4];
    assign rf = ir[P_REG_ADDR_WIDTH-1:0];

    // Decode priority: all-ones register field overrides every opcode.
    always_comb begin
        d_jump       = 1'b0;
        d_store_word = 1'b0;
        d_store_pc   = 1'b0;
        d_load_word  = 1'b0;
        d_wb         = 1'b0;
        d_reg        = '0;
        if ((&rf) || op == 4'b1011 || op == 4'b1100) begin
            d_wb  = 1'b1;
            d_reg = '1;
        end else begin
            case (op)
                4'b1110: begin d_store_word = 1'b1; d_reg = rf; end
                4'b1101: begin d_load_word = 1'b1; d_wb = 1'b1; d_reg = rf; end
                4'b1010: begin d_jump = 1'b1; d_store_pc = 1'b1; d_wb = 1'b1; d_reg = rf; end
                4'b1001: begin d_jump = w_cf; d_reg = rf; end
                4'b0111, 4'b1000: d_reg = rf;
                4'b0000: d_reg = '0;
                default: begin d_wb = 1'b1; d_reg = rf; end
            endcase
        end
    end

    always_ff @(posedge w_clock or posedge w_reset) begin
        if (w_reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state            = state;
        w_instr_ready         = 1'b0;
        w_pc_enable           = 1'b0;
        w_mem_req             = 1'b0;
        w_data_mem_write_flag = 1'b0;
        w_write_back_flag     = 1'b0;
        timeout               = 1'b0;
        unique case (state)
            S_FETCH: begin
                w_instr_ready = 1'b1;
                if (w_instr_valid) next_state = S_DECODE;
            end
            S_DECODE: next_state = S_EXECUTE;
            S_EXECUTE: begin
                if (load_word_q || store_word_q) begin
                    next_state = S_MEM;
                end else if (wb_q) begin
                    next_state = S_WRITEBACK;
                end else begin
                    next_state  = S_FETCH;
                    w_pc_enable = 1'b1;
                end
            end
            S_MEM: begin
                w_mem_req             = 1'b1;
                w_data_mem_write_flag = store_word_q;
                if (w_mem_ack) begin
                    if (load_word_q) begin
                        next_state = S_WRITEBACK;
                    end else begin
                        next_state  = S_FETCH;
                        w_pc_enable = 1'b1;
                    end
                end else if (TIMEOUT_EN && timer == '0) begin
                    timeout    = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_WRITEBACK: begin
                w_write_back_flag = 1'b1;
                w_pc_enable       = 1'b1;
                next_state        = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Decoded flags live from EXECUTE until the return to FETCH.
    always_ff @(posedge w_clock or posedge w_reset) begin
        if (w_reset) begin
            ir           <= '0;
            jump_q       <= 1'b0;
            store_word_q <= 1'b0;
            store_pc_q   <= 1'b0;
            load_word_q  <= 1'b0;
            wb_q         <= 1'b0;
            reg_q        <= '0;
            timer        <= '0;
            mem_error_q  <= 1'b0;
        end else begin
            mem_error_q <= timeout;
            if (state == S_FETCH && w_instr_valid) ir <= w_bus_wordin;
            if (state == S_EXECUTE) begin
                timer <= TW'(P_MEM_TIMEOUT - 1);
            end else if (state == S_MEM && timer != '0) begin
                timer <= timer - 1'b1;
            end
            if (state == S_DECODE) begin
                jump_q       <= d_jump;
                store_word_q <= d_store_word;
                store_pc_q   <= d_store_pc;
                load_word_q  <= d_load_word;
                wb_q         <= d_wb;
                reg_q        <= d_reg;
            end else if (next_state == S_FETCH) begin
                jump_q       <= 1'b0;
                store_word_q <= 1'b0;
                store_pc_q   <= 1'b0;
                load_word_q  <= 1'b0;
                wb_q         <= 1'b0;
                reg_q        <= '0;
            end
        end
    end

    assign w_jump_flag       = jump_q;
    assign w_store_word_flag = store_word_q;
    assign w_store_pc_flag   = store_pc_q;
    assign w_load_word_flag  = load_word_q;
    assign w_write_back_reg  = reg_q;
    assign w_state           = state;
    assign w_mem_error       = TIMEOUT_EN & mem_error_q;

endmodule

// File: tb/tb_m_multicycle_control_unit.sv
// Scoreboard bench for m_multicycle_control_unit: directed instructions, retire events checked by a monitor.
// Define CU_MEM_TIMEOUT_EN to also exercise the MEM timeout path.
module tb_m_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] word_in = '0;
    logic       valid = 1'b0, cf_in = 1'b0, ack = 1'b0;
    logic       w_instr_ready, w_jump_flag, w_store_word_flag, w_store_pc_flag, w_load_word_flag;
    logic       w_data_mem_write_flag, w_write_back_flag, w_mem_req, w_pc_enable, w_mem_error;
    logic [3:0] w_write_back_reg;
    logic [2:0] w_state;

    int checks = 0, failures = 0;

    m_multicycle_control_unit #(.P_WORD_WIDTH(8), .P_REG_ADDR_WIDTH(4), .P_MEM_TIMEOUT(4)) dut (
        .w_clock(clk), .w_reset(rst), .w_bus_wordin(word_in), .w_instr_valid(valid),
        .w_cf(cf_in), .w_mem_ack(ack), .w_instr_ready(w_instr_ready),
        .w_jump_flag(w_jump_flag), .w_store_word_flag(w_store_word_flag),
        .w_store_pc_flag(w_store_pc_flag), .w_load_word_flag(w_load_word_flag),
        .w_data_mem_write_flag(w_data_mem_write_flag), .w_write_back_flag(w_write_back_flag),
        .w_write_back_reg(w_write_back_reg), .w_mem_req(w_mem_req), .w_pc_enable(w_pc_enable),
        .w_state(w_state), .w_mem_error(w_mem_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        int         wbp;
        bit         chk_reg;
        logic [3:0] rg;
        logic       jump, sw, spc, lw, pc, err;
        int         cyc, req, mw;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] st, input int wbp, input bit cr, input logic [3:0] rg,
                                input logic j, input logic sw, input logic spc, input logic lw,
                                input logic pc, input logic err, input int cyc, input int req, input int mw);
        exp_t r;
        r.st = st; r.wbp = wbp; r.chk_reg = cr; r.rg = rg;
        r.jump = j; r.sw = sw; r.spc = spc; r.lw = lw; r.pc = pc; r.err = err;
        r.cyc = cyc; r.req = req; r.mw = mw;
        return r;
    endfunction

    // Monitor: tracks each instruction from acceptance to its retire cycle (pc_enable or mem_error).
    bit active = 1'b0;
    int cyc_n, req_n, mw_n, wb_n, wb_total = 0;

    always @(negedge clk) begin
        if (active) begin
            cyc_n++;
            if (w_mem_req) req_n++;
            if (w_data_mem_write_flag) mw_n++;
            if (w_write_back_flag) wb_n++;
            if (w_pc_enable || w_mem_error) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("retire_state", int'(w_state), int'(e.st));
                    chk("wb_pulses", wb_n, e.wbp);
                    if (e.chk_reg) chk("wb_reg", int'(w_write_back_reg), int'(e.rg));
                    chk("jump", int'(w_jump_flag), int'(e.jump));
                    chk("store_word", int'(w_store_word_flag), int'(e.sw));
                    chk("store_pc", int'(w_store_pc_flag), int'(e.spc));
                    chk("load_word", int'(w_load_word_flag), int'(e.lw));
                    chk("pc_enable", int'(w_pc_enable), int'(e.pc));
                    chk("mem_error", int'(w_mem_error), int'(e.err));
                    chk("latency", cyc_n, e.cyc);
                    chk("mem_req_cycles", req_n, e.req);
                    chk("mem_write_cycles", mw_n, e.mw);
                end
                active = 1'b0;
            end
        end
        if (w_write_back_flag) wb_total++;
        if (!rst && (w_state == 3'd0 || w_state == 3'd1))
            chk("flags_idle", int'({w_jump_flag, w_store_word_flag, w_store_pc_flag, w_load_word_flag, w_write_back_reg}), 0);
        if (!rst && w_state == 3'd0 && valid) begin
            active = 1'b1; cyc_n = 1; req_n = 0; mw_n = 0; wb_n = 0;
        end
    end

    // ack_at: MEM cycle index (0 = entry cycle) in which ack is raised; noise drives valid/ack outside FETCH/MEM.
    task automatic run_instr(input logic [7:0] word, input logic cf, input int ack_at, input bit noise);
        int n, mem_i;
        n = 0;
        while (w_state !== 3'd0 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("ready_wait_expired", 0, 1);
        word_in = word; cf_in = cf; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        mem_i = 0; n = 0;
        while (w_state !== 3'd0 && n < 60) begin
            ack = 1'b0;
            if (w_state == 3'd3) begin
                if (mem_i == ack_at) ack = 1'b1;
                mem_i++;
            end else if (noise) begin
                valid = 1'b1; word_in = 8'hFF; ack = 1'b1;
            end
            @(posedge clk); #1; n++;
        end
        valid = 1'b0; ack = 1'b0;
        if (n >= 60) chk("return_wait_expired", 0, 1);
    endtask

    initial begin
        #2;
        chk("rst_state", int'(w_state), 0);
        chk("rst_ready", int'(w_instr_ready), 1);
        chk("rst_outputs", int'({w_jump_flag, w_store_word_flag, w_store_pc_flag, w_load_word_flag,
            w_data_mem_write_flag, w_write_back_flag, w_write_back_reg, w_mem_req, w_pc_enable, w_mem_error}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1 chk("ready_after_rst", int'(w_instr_ready), 1);

        //                st   wbp reg?  rg    j  sw spc lw  pc err cyc req mw
        exp_q.push_back(mk(3'd4, 1, 1, 4'h3, 0, 0, 0, 0, 1, 0, 4, 0, 0));
        run_instr(8'h23, 1'b0, 99, 1'b1);
        exp_q.push_back(mk(3'd2, 0, 0, 4'h0, 1, 0, 0, 0, 1, 0, 3, 0, 0));
        run_instr(8'h95, 1'b1, 99, 1'b0);
        exp_q.push_back(mk(3'd2, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 3, 0, 0));
        run_instr(8'h95, 1'b0, 99, 1'b0);
        exp_q.push_back(mk(3'd4, 1, 1, 4'h7, 0, 0, 0, 1, 1, 0, 7, 3, 0));
        run_instr(8'hD7, 1'b0, 2, 1'b0);
        exp_q.push_back(mk(3'd3, 0, 1, 4'h2, 0, 1, 0, 0, 1, 0, 4, 1, 1));
        run_instr(8'hE2, 1'b0, 0, 1'b0);
        exp_q.push_back(mk(3'd4, 1, 1, 4'h4, 1, 0, 1, 0, 1, 0, 4, 0, 0));
        run_instr(8'hA4, 1'b0, 99, 1'b0);
        exp_q.push_back(mk(3'd2, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 3, 0, 0));
        run_instr(8'h00, 1'b1, 99, 1'b0);
        exp_q.push_back(mk(3'd4, 1, 1, 4'hF, 0, 0, 0, 0, 1, 0, 4, 0, 0));
        run_instr(8'h7F, 1'b0, 99, 1'b0);
        exp_q.push_back(mk(3'd4, 1, 1, 4'hF, 0, 0, 0, 0, 1, 0, 4, 0, 0));
        run_instr(8'hB2, 1'b0, 99, 1'b0);
        exp_q.push_back(mk(3'd2, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 3, 0, 0));
        run_instr(8'h72, 1'b0, 99, 1'b0);
        exp_q.push_back(mk(3'd4, 1, 1, 4'h1, 0, 0, 0, 0, 1, 0, 4, 0, 0));
        run_instr(8'hF1, 1'b0, 99, 1'b0);
        exp_q.push_back(mk(3'd4, 1, 1, 4'hF, 0, 0, 0, 0, 1, 0, 4, 0, 0));
        run_instr(8'hDF, 1'b0, 99, 1'b0);
`ifdef CU_MEM_TIMEOUT_EN
        exp_q.push_back(mk(3'd0, 0, 1, 4'h0, 0, 0, 0, 0, 0, 1, 8, 4, 0));
        run_instr(8'hD1, 1'b0, 99, 1'b0);
`endif

        // Reset in the middle of a load's MEM wait.
        begin
            int n, wb_before;
            word_in = 8'hD7; valid = 1'b1;
            @(posedge clk); #1;
            valid = 1'b0;
            n = 0;
            while (w_state !== 3'd3 && n < 20) begin @(posedge clk); #1; n++; end
            if (n >= 20) chk("mem_wait_expired", 0, 1);
            @(posedge clk); #1;
            chk("still_in_mem", int'(w_state), 3);
            wb_before = wb_total;
            #2 rst = 1'b1;
            #1;
            chk("midrst_state", int'(w_state), 0);
            chk("midrst_mem_req", int'(w_mem_req), 0);
            chk("midrst_outputs", int'({w_jump_flag, w_store_word_flag, w_store_pc_flag, w_load_word_flag,
                w_data_mem_write_flag, w_write_back_flag, w_write_back_reg, w_pc_enable, w_mem_error}), 0);
            @(posedge clk); @(posedge clk); #1;
            rst = 1'b0;
            #1;
            chk("ready_after_midrst", int'(w_instr_ready), 1);
            chk("state_after_midrst", int'(w_state), 0);
            repeat (3) @(posedge clk);
            #1;
            chk("no_wb_after_midrst", wb_total, wb_before);
        end

        exp_q.push_back(mk(3'd4, 1, 1, 4'h3, 0, 0, 0, 0, 1, 0, 4, 0, 0));
        run_instr(8'h23, 1'b0, 99, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
